cnn_layer_feeder: RTL and testbench
===================================

CNN_LAYER_FEEDER -- requirements
Module: cnn_layer_feeder

Interface
REQ-001 The block SHALL have parameter IMG_DIM, default 6, meaning image side length in pixels (image is IMG_DIM x IMG_DIM).
REQ-002 The block SHALL have parameter K, default 3, meaning filter side length (filter is K x K).
REQ-003 The block SHALL have parameter D, default 4, meaning pixel width (unsigned).
REQ-004 The block SHALL have parameter F, default 4, meaning filter weight width (signed).
REQ-005 The block SHALL have parameter PIPE_LAT, default 2, meaning idle cycles between the last image beat and the first ReadEn.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 The block SHALL have port wr_en, input, 1 bit, the host buffer write strobe.
REQ-009 The block SHALL have port wr_sel, input, 1 bit, selecting the written buffer: 0 = image, 1 = filter.
REQ-010 The block SHALL have port wr_addr, input, 6 bits, the raster-order buffer address.
REQ-011 The block SHALL have port wr_data, input, max(D,F) bits, the write data; the low D or F bits are used.
REQ-012 The block SHALL have port go, input, 1 bit, a request to stream one layer pass.
REQ-013 The block SHALL have port busy, output, 1 bit, high from the cycle after go is accepted through the done cycle.
REQ-014 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-015 The block SHALL have ports Start (output, 1 bit), Image (output, D bits), Filter (output, signed F bits) and ReadEn (output, 1 bit), which drive the conv layer.

Function
REQ-016 The block SHALL hold an image buffer of IMG_DIM^2 x D bits and a filter buffer of K^2 x F bits, written on clk when wr_en=1 and busy=0.
REQ-017 The block SHALL ignore any write with wr_addr >= buffer depth, and any write made while busy=1; buffer contents SHALL be unchanged in both cases.
REQ-018 The FSM SHALL have the states IDLE, START, FILT, IMG, WAIT, READ and DONE.
REQ-019 In IDLE, go=1 SHALL move the FSM to START; go SHALL be ignored in every other state.
REQ-020 In START, Start SHALL be 1 for exactly one cycle, and the FSM SHALL then move to FILT.
REQ-021 In FILT, Filter SHALL present weights 0..K^2-1 in raster order, one per cycle for K^2 cycles, and the FSM SHALL then move to IMG.
REQ-022 In IMG, Image SHALL present pixels 0..IMG_DIM^2-1 in raster order, one per cycle, and the FSM SHALL then move to WAIT.
REQ-023 In WAIT, the FSM SHALL stay for PIPE_LAT cycles; PIPE_LAT=0 SHALL go directly to READ.
REQ-024 In READ, ReadEn SHALL be 1 for exactly (IMG_DIM-K+1)^2 consecutive cycles (16 at the defaults).
REQ-025 The FSM SHALL pass through DONE for one cycle with done=1 and then return to IDLE.
REQ-026 Image SHALL be 0 outside IMG, and Filter SHALL be 0 outside FILT; all outputs SHALL be registered, with no combinational path from an input to an output.
REQ-027 go=1 in the same cycle as the done pulse SHALL be ignored; go=1 on the cycle after DONE (in IDLE) SHALL be accepted.
REQ-028 A write and go in the same IDLE cycle SHALL both take effect, and the written value SHALL be streamed.
REQ-029 Beat counters SHALL clear on every state entry, so that no count carries over between passes.
REQ-030 Total pass length SHALL be 1 + K^2 + IMG_DIM^2 + PIPE_LAT + (IMG_DIM-K+1)^2 + 1 cycles from START entry to IDLE (65 cycles at the defaults).

Reset
REQ-031 When rst=1, the FSM SHALL be in IDLE, and busy, done, Start, ReadEn, Image and Filter SHALL all be 0 on the next edge.
REQ-032 Reset asserted mid-pass SHALL abort the pass with no done pulse, and the buffer contents SHALL be retained.
REQ-033 Buffers SHALL not be cleared by reset; they are undefined until written.

Configuration
REQ-034 When macro FEEDER_WR_ERR_EN is defined, the block SHALL add output wr_err, 1 bit, sticky, set by any ignored write (busy or out-of-range), and cleared only by rst or by go being accepted.
REQ-035 When FEEDER_WR_ERR_EN is undefined, port wr_err SHALL be absent, and ignored writes SHALL be silently dropped.

Verification
REQ-036 Load pixels p[i]=i mod 16 and weights w[i]=i-4, pulse go -> Start high 1 cycle, then Filter = -4..4, then Image = 0..15,0..15,0..3, then 2 idle cycles, then ReadEn for 16 cycles, then done; the total is 65 cycles.
REQ-037 Write image address 5 = 9 while busy, then run a second pass -> Image beat 5 still carries the old value; with FEEDER_WR_ERR_EN, wr_err=1 until go.
REQ-038 Assert rst at the 10th IMG beat -> all outputs 0 next cycle, no done; a following go streams the unchanged buffers.
REQ-039 Hold go high continuously -> passes run back-to-back with exactly one IDLE cycle between done and the next Start.
REQ-040 With PIPE_LAT=0 and IMG_DIM=4 -> ReadEn rises the cycle after the last Image beat and stays high for 4 cycles.

Source files
------------

// File: rtl/cnn_layer_feeder.sv
`default_nettype none
// =============================================================================
// cnn_layer_feeder : buffers one image and one filter, then streams a layer pass
//                    (Start, weights, pixels, latency gap, ReadEn window, done).
// Optional macro FEEDER_WR_ERR_EN adds the sticky wr_err flag.   Rev 1.0
// =============================================================================
module cnn_layer_feeder #(
   parameter int IMG_DIM  = 6,
   parameter int K        = 3,
   parameter int D        = 4,
   parameter int F        = 4,
   parameter int PIPE_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     wr_sel,
   input  logic [5:0]               wr_addr,
   input  logic [(D>F?D:F)-1:0]     wr_data,
   input  logic                     go,
   output logic                     busy,
   output logic                     done,
   output logic                     Start,
   output logic [D-1:0]             Image,
   output logic signed [F-1:0]      Filter,
   output logic                     ReadEn
`ifdef FEEDER_WR_ERR_EN
   ,
   output logic                     wr_err
`endif
);

   localparam int c_IMG_N = IMG_DIM * IMG_DIM;
   localparam int c_K2    = K * K;
   localparam int c_OUT_N = (IMG_DIM - K + 1) * (IMG_DIM - K + 1);
   localparam int c_M1    = (c_IMG_N > c_K2) ? c_IMG_N : c_K2;
   localparam int c_M2    = (c_OUT_N > PIPE_LAT) ? c_OUT_N : PIPE_LAT;
   localparam int c_MAX   = (c_M1 > c_M2) ? c_M1 : c_M2;
   localparam int c_CNT_W = $clog2(c_MAX + 1);
   localparam int c_IA_W  = $clog2(c_IMG_N);
   localparam int c_FA_W  = $clog2(c_K2);

   localparam logic [c_CNT_W-1:0] c_FILT_LAST = c_CNT_W'(c_K2 - 1);
   localparam logic [c_CNT_W-1:0] c_IMG_LAST  = c_CNT_W'(c_IMG_N - 1);
   localparam logic [c_CNT_W-1:0] c_LAT_LAST  = c_CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
   localparam logic [c_CNT_W-1:0] c_READ_LAST = c_CNT_W'(c_OUT_N - 1);
   localparam logic [6:0]         c_IMG_DEPTH = 7'(c_IMG_N);
   localparam logic [6:0]         c_FLT_DEPTH = 7'(c_K2);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_START = 3'd1;
   localparam logic [2:0] c_FILT  = 3'd2;
   localparam logic [2:0] c_IMG   = 3'd3;
   localparam logic [2:0] c_WAIT  = 3'd4;
   localparam logic [2:0] c_READ  = 3'd5;
   localparam logic [2:0] c_DONE  = 3'd6;

   logic [2:0]          r_state, w_nstate;
   logic [c_CNT_W-1:0]  r_cnt, w_ncnt;
   logic [D-1:0]        r_img_mem  [0:c_IMG_N-1];
   logic signed [F-1:0] r_filt_mem [0:c_K2-1];

   logic w_idle, w_go_acc, w_img_ok, w_flt_ok, w_img_we, w_flt_we;

   assign w_idle   = (r_state == c_IDLE);
   assign w_go_acc = w_idle & go;
   assign w_img_ok = ({1'b0, wr_addr} < c_IMG_DEPTH);
   assign w_flt_ok = ({1'b0, wr_addr} < c_FLT_DEPTH);
   assign w_img_we = wr_en & w_idle & ~wr_sel & w_img_ok;
   assign w_flt_we = wr_en & w_idle &  wr_sel & w_flt_ok;

   // Counter restarts at 0 on every state change so passes never inherit a count.
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = '0;
      case (r_state)
         c_IDLE:  if (go) w_nstate = c_START;
         c_START: w_nstate = c_FILT;
         c_FILT:  if (r_cnt == c_FILT_LAST) w_nstate = c_IMG;
                  else w_ncnt = r_cnt + 1'b1;
         c_IMG:   if (r_cnt == c_IMG_LAST) w_nstate = (PIPE_LAT == 0) ? c_READ : c_WAIT;
                  else w_ncnt = r_cnt + 1'b1;
         c_WAIT:  if (r_cnt == c_LAT_LAST) w_nstate = c_READ;
                  else w_ncnt = r_cnt + 1'b1;
         c_READ:  if (r_cnt == c_READ_LAST) w_nstate = c_DONE;
                  else w_ncnt = r_cnt + 1'b1;
         c_DONE:  w_nstate = c_IDLE;
         default: w_nstate = c_IDLE;
      endcase
   end

   // Outputs are loaded from the next state, so each one is a flop aligned with its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Start   <= 1'b0;
         ReadEn  <= 1'b0;
         Image   <= '0;
         Filter  <= '0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         busy    <= (w_nstate != c_IDLE);
         done    <= (w_nstate == c_DONE);
         Start   <= (w_nstate == c_START);
         ReadEn  <= (w_nstate == c_READ);
         Image   <= (w_nstate == c_IMG)  ? r_img_mem[w_ncnt[c_IA_W-1:0]]  : '0;
         Filter  <= (w_nstate == c_FILT) ? r_filt_mem[w_ncnt[c_FA_W-1:0]] : '0;
      end
   end

   // Buffers are deliberately outside reset so an aborted pass keeps its data.
   always_ff @(posedge clk) begin
      if (w_img_we) r_img_mem[wr_addr[c_IA_W-1:0]] <= wr_data[D-1:0];
      if (w_flt_we) r_filt_mem[wr_addr[c_FA_W-1:0]] <= wr_data[F-1:0];
   end

`ifdef FEEDER_WR_ERR_EN
   logic w_wr_bad;
   assign w_wr_bad = wr_en & (~w_idle | (wr_sel ? ~w_flt_ok : ~w_img_ok));

   // A dropped write in the same cycle as go still leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst)           wr_err <= 1'b0;
      else if (w_wr_bad) wr_err <= 1'b1;
      else if (w_go_acc) wr_err <= 1'b0;
   end
`else
   logic w_unused;
   assign w_unused = w_go_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_feeder.sv
`default_nettype none
// Directed bench for cnn_layer_feeder at default parameters: per-cycle vector
// table for whole passes plus reset-abort and back-to-back sequences.
module tb_cnn_layer_feeder;

   logic       clk = 1'b0;
   logic       rst, wr_en, wr_sel, go;
   logic [5:0] wr_addr;
   logic [3:0] wr_data;
   logic       busy, done, Start, ReadEn;
   logic [3:0] Image;
   logic signed [3:0] Filter;
`ifdef FEEDER_WR_ERR_EN
   logic       wr_err;
`endif

   cnn_layer_feeder dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .go(go), .busy(busy), .done(done), .Start(Start),
      .Image(Image), .Filter(Filter), .ReadEn(ReadEn)
`ifdef FEEDER_WR_ERR_EN
      , .wr_err(wr_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       go, wr_en, wr_sel;
      logic [5:0] wr_addr;
      logic [3:0] wr_data;
      logic       e_busy, e_done, e_start, e_readen;
      logic [3:0] e_img;
      logic signed [3:0] e_filt;
   } vec_t;

   vec_t tv [0:199];
   logic [3:0]        m_img  [0:35];
   logic signed [3:0] m_filt [0:8];
   int n_checks = 0;
   int n_errors = 0;
   string cur_tag;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic sel, input logic [5:0] addr, input logic [3:0] data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
      step();
      wr_en = 1'b0;
   endtask

   // Timeline of one pass relative to the row where go is driven (row base).
   task automatic fill_pass(input int base, input bit hold);
      for (int k = 0; k <= 66; k++) begin
         vec_t v;
         v.go = (k == 0) || (hold && k <= 65);
         v.wr_en = 1'b0; v.wr_sel = 1'b0; v.wr_addr = '0; v.wr_data = '0;
         v.e_busy   = (k >= 1 && k <= 65);
         v.e_start  = (k == 1);
         v.e_done   = (k == 65);
         v.e_readen = (k >= 49 && k <= 64);
         v.e_filt   = (k >= 2 && k <= 10)  ? m_filt[k-2] : 4'sd0;
         v.e_img    = (k >= 11 && k <= 46) ? m_img[k-11] : 4'd0;
         tv[base+k] = v;
      end
   endtask

   task automatic check_row(input int j);
      vec_t v;
      v = tv[j];
      n_checks++;
      if (busy !== v.e_busy || done !== v.e_done || Start !== v.e_start ||
          ReadEn !== v.e_readen || Image !== v.e_img || Filter !== v.e_filt) begin
         n_errors++;
         $display("FAIL %s row %0d: got busy=%b done=%b start=%b readen=%b image=%0d filter=%0d, expected busy=%b done=%b start=%b readen=%b image=%0d filter=%0d",
                  cur_tag, j, busy, done, Start, ReadEn, Image, Filter,
                  v.e_busy, v.e_done, v.e_start, v.e_readen, v.e_img, v.e_filt);
      end
   endtask

   task automatic run_table(input int first, input int last);
      for (int j = first; j <= last; j++) begin
         check_row(j);
         go = tv[j].go; wr_en = tv[j].wr_en; wr_sel = tv[j].wr_sel;
         wr_addr = tv[j].wr_addr; wr_data = tv[j].wr_data;
         step();
      end
      go = 1'b0; wr_en = 1'b0;
   endtask

   task automatic check_idle(input string name);
      n_checks++;
      if ({busy, done, Start, ReadEn} !== 4'b0 || Image !== 4'd0 || Filter !== 4'sd0) begin
         n_errors++;
         $display("FAIL %s: got busy=%b done=%b start=%b readen=%b image=%0d filter=%0d, expected all zero",
                  name, busy, done, Start, ReadEn, Image, Filter);
      end
   endtask

`ifdef FEEDER_WR_ERR_EN
   task automatic check_err(input string name, input logic exp);
      n_checks++;
      if (wr_err !== exp) begin
         n_errors++;
         $display("FAIL %s: got wr_err=%b, expected %b", name, wr_err, exp);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; go = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      step(); step(); step();
      check_idle("reset");
      rst = 1'b0;

      for (int i = 0; i < 36; i++) begin
         m_img[i] = 4'(i % 16);
         do_write(1'b0, 6'(i), m_img[i]);
      end
      for (int i = 0; i < 9; i++) begin
         m_filt[i] = 4'(i - 4);
         do_write(1'b1, 6'(i), m_filt[i]);
      end
      // Out-of-range writes; filter address 16 would alias weight 0 if not dropped.
      do_write(1'b1, 6'd16, 4'd7);
      do_write(1'b0, 6'd40, 4'd15);
`ifdef FEEDER_WR_ERR_EN
      check_err("wr_err after out-of-range write", 1'b1);
`endif

      // Pass 1: nominal stream, write while busy, go during done ignored.
      cur_tag = "pass1";
      fill_pass(0, 1'b0);
      tv[20].wr_en = 1'b1; tv[20].wr_sel = 1'b0; tv[20].wr_addr = 6'd5; tv[20].wr_data = 4'd9;
      tv[65].go = 1'b1;
      tv[67] = tv[66];
      run_table(0, 67);
`ifdef FEEDER_WR_ERR_EN
      check_err("wr_err after busy write", 1'b1);
`endif

      // Pass 2: write together with go is streamed; the busy write left beat 5 alone.
      cur_tag = "pass2";
      m_img[0] = 4'd11;
      fill_pass(0, 1'b0);
      tv[0].wr_en = 1'b1; tv[0].wr_sel = 1'b0; tv[0].wr_addr = 6'd0; tv[0].wr_data = 4'd11;
      run_table(0, 0);
`ifdef FEEDER_WR_ERR_EN
      check_err("wr_err cleared by go", 1'b0);
`endif
      run_table(1, 66);

      // Reset during the 10th image beat aborts the pass without done.
      cur_tag = "abort";
      fill_pass(0, 1'b0);
      run_table(0, 19);
      check_row(20);
      rst = 1'b1;
      step();
      check_idle("reset mid-pass");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle("idle after abort");
      end
      cur_tag = "after_abort";
      run_table(0, 66);

      // go held high: one IDLE cycle between done and the next Start.
      cur_tag = "back2back";
      fill_pass(0, 1'b1);
      fill_pass(66, 1'b1);
      run_table(0, 132);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1);
   end

endmodule
`default_nettype wire
